// File: rtl/cdc_xfer_arbiter_pkg.sv
// cdc_xfer_arbiter_pkg: shared synchronizer depth and transfer FSM encoding
package cdc_xfer_arbiter_pkg;
  localparam int DEFAULT_NSYNC = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2} state_t;
endpackage

// File: rtl/cdc_xfer_arbiter_rr.sv
// rr_arbiter_nreq: round-robin winner search starting just after the last grant
module rr_arbiter_nreq #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic [$clog2(NREQ)-1:0] winner,
  output logic                    valid
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] idx;
  always_comb begin
    winner = '0;
    valid = 1'b0;
    idx = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NREQ);
      if (req[idx]) begin
        winner = idx;
        valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sync_wire.sv
// sync_wire: multi-flop synchronizer for asynchronous level/toggle signals
module sync_wire #(
  parameter int NOUT  = 1,
  parameter int NSYNC = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NOUT-1:0] d,
  output logic [NOUT-1:0] q
);
  logic [NSYNC-1:0][NOUT-1:0] ff;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ff <= '0;
    else ff <= {ff[NSYNC-2:0], d};
  assign q = ff[NSYNC-1];
endmodule

// File: rtl/cdc_xfer_arbiter.sv
// cdc_xfer_arbiter: round-robin sharing of one toggle-handshake CDC channel with timeout recovery
module cdc_xfer_arbiter
  import cdc_xfer_arbiter_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int DW     = 16,
  parameter int NSYNC  = DEFAULT_NSYNC,
  parameter int TOUT_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] data,
  output logic [NREQ-1:0]    grant,
  output logic [NREQ-1:0]    done,
  output logic [DW-1:0]      xfer_data,
  output logic               xfer_tgl,
  input  logic               ack_tgl_async,
  output logic               busy,
  output logic               tout_err
);
  localparam int IW = $clog2(NREQ);
  state_t state;
  logic [IW-1:0] rr_last, winner;
  logic valid, ack_s;
  logic [TOUT_W-1:0] cnt;
  sync_wire #(.NOUT(1), .NSYNC(NSYNC)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ack_tgl_async),
    .q     (ack_s)
  );
  rr_arbiter_nreq #(.NREQ(NREQ)) u_arb (
    .req    (req),
    .last   (rr_last),
    .winner (winner),
    .valid  (valid)
  );
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      grant <= '0;
      done <= '0;
      xfer_data <= '0;
      xfer_tgl <= 1'b0;
      tout_err <= 1'b0;
      cnt <= '0;
      rr_last <= IW'(NREQ - 1);
    end else begin
      done <= '0;
      tout_err <= 1'b0;
      case (state)
        IDLE:
          if (valid && ack_s == xfer_tgl) begin
            grant <= NREQ'(1) << winner;
            xfer_data <= data[winner*DW +: DW];
            rr_last <= winner;
            state <= SEND;
          end
        SEND: begin
          xfer_tgl <= ~xfer_tgl;
          cnt <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (ack_s == xfer_tgl) begin
            done <= grant;
            grant <= '0;
            state <= IDLE;
          end else if (&cnt) begin
            tout_err <= 1'b1;
            grant <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule
